// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle control unit: state encoding,
// ALU class codes, opcode/funct values and the decoded control bundle.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_EXR   = 4'd2,
        S_EXI   = 4'd3,
        S_WBALU = 4'd4,
        S_ADDR  = 4'd5,
        S_MRD   = 4'd6,
        S_WBMEM = 4'd7,
        S_MWR   = 4'd8,
        S_BR    = 4'd9,
        S_JMP   = 4'd10,
        S_JR    = 4'd11,
        S_EXC   = 4'd12
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_R   = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_write;
        logic       mem_read;
        logic       ir_write;
        logic       reg_write;
        logic       ext_op;
        logic       lui_op;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       branch_ne;
        logic       epc_write;
        logic       exc_vec;
        logic       illegal;
        logic [2:0] alu_class;
        logic       alu_unsigned;
    } ctrl_t;

    function automatic logic is_shift_funct(input logic [5:0] f);
        return (f == F_SLL) || (f == F_SRL) || (f == F_SRA);
    endfunction

    function automatic logic is_legal_funct(input logic [5:0] f);
        case (f)
            6'h00, 6'h02, 6'h03, 6'h08, 6'h09,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
            6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational decode: current state + OpCode/Funct (+ mem_ready) to
// datapath controls, next state and the retire strobe.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_HANDSHAKE = 1,
    parameter int unsigned EXC_ENABLE    = 1
) (
    input  state_e     i_state,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl_c,
    output state_e     o_next_c,
    output logic       o_retire_c
);

    logic   w_rdy;
    state_e w_bad_dest;

    assign w_rdy      = (MEM_HANDSHAKE != 0) ? i_mem_ready : 1'b1;
    assign w_bad_dest = (EXC_ENABLE != 0) ? S_EXC : S_IF;

    always_comb begin
        o_ctrl_c   = '0;
        o_next_c   = i_state;
        o_retire_c = 1'b0;
        case (i_state)
            S_IF: begin
                o_ctrl_c.mem_read     = 1'b1;
                o_ctrl_c.alu_src_b    = 2'b01;
                o_ctrl_c.alu_class    = ALU_ADD;
                o_ctrl_c.alu_unsigned = i_opcode[0];
                o_ctrl_c.ir_write     = w_rdy;
                o_ctrl_c.pc_write     = w_rdy;
                if (w_rdy) o_next_c = S_ID;
            end
            S_ID: begin
                o_ctrl_c.alu_src_b    = 2'b11;
                o_ctrl_c.ext_op       = 1'b1;
                o_ctrl_c.alu_class    = ALU_ADD;
                o_ctrl_c.alu_unsigned = i_opcode[0];
                case (i_opcode)
                    OP_RTYPE: begin
                        if ((i_funct == F_JR) || (i_funct == F_JALR)) o_next_c = S_JR;
                        else if (is_legal_funct(i_funct))             o_next_c = S_EXR;
                        else                                          o_next_c = w_bad_dest;
                    end
                    OP_LW, OP_SW:                         o_next_c = S_ADDR;
                    OP_ADDI, OP_ADDIU, OP_SLTI,
                    OP_SLTIU, OP_ANDI, OP_LUI:            o_next_c = S_EXI;
                    OP_BEQ, OP_BNE:                       o_next_c = S_BR;
                    OP_J, OP_JAL:                         o_next_c = S_JMP;
                    default:                              o_next_c = w_bad_dest;
                endcase
            end
            S_EXR: begin
                o_ctrl_c.alu_src_a    = is_shift_funct(i_funct) ? 2'b10 : 2'b01;
                o_ctrl_c.alu_class    = ALU_R;
                o_ctrl_c.alu_unsigned = i_opcode[0];
                o_next_c              = S_WBALU;
            end
            S_EXI: begin
                o_ctrl_c.alu_src_a    = 2'b01;
                o_ctrl_c.alu_src_b    = 2'b10;
                o_ctrl_c.ext_op       = (i_opcode != OP_ANDI);
                o_ctrl_c.lui_op       = (i_opcode == OP_LUI);
                o_ctrl_c.alu_unsigned = i_opcode[0];
                if (i_opcode == OP_ANDI)
                    o_ctrl_c.alu_class = ALU_AND;
                else if ((i_opcode == OP_SLTI) || (i_opcode == OP_SLTIU))
                    o_ctrl_c.alu_class = ALU_SLT;
                else
                    o_ctrl_c.alu_class = ALU_ADD;
                o_next_c = S_WBALU;
            end
            S_WBALU: begin
                o_ctrl_c.reg_write  = 1'b1;
                o_ctrl_c.mem_to_reg = 2'b01;
                o_ctrl_c.reg_dst    = (i_opcode == OP_RTYPE) ? 2'b01 : 2'b00;
                o_next_c            = S_IF;
                o_retire_c          = 1'b1;
            end
            S_ADDR: begin
                o_ctrl_c.alu_src_a    = 2'b01;
                o_ctrl_c.alu_src_b    = 2'b10;
                o_ctrl_c.ext_op       = 1'b1;
                o_ctrl_c.alu_class    = ALU_ADD;
                o_ctrl_c.alu_unsigned = i_opcode[0];
                o_next_c              = (i_opcode == OP_SW) ? S_MWR : S_MRD;
            end
            S_MRD: begin
                o_ctrl_c.mem_read = 1'b1;
                o_ctrl_c.iord     = 1'b1;
                if (w_rdy) o_next_c = S_WBMEM;
            end
            S_WBMEM: begin
                o_ctrl_c.reg_write = 1'b1;
                o_next_c           = S_IF;
                o_retire_c         = 1'b1;
            end
            S_MWR: begin
                o_ctrl_c.mem_write = 1'b1;
                o_ctrl_c.iord      = 1'b1;
                if (w_rdy) begin
                    o_next_c   = S_IF;
                    o_retire_c = 1'b1;
                end
            end
            S_BR: begin
                o_ctrl_c.alu_src_a     = 2'b01;
                o_ctrl_c.alu_class     = ALU_SUB;
                o_ctrl_c.alu_unsigned  = i_opcode[0];
                o_ctrl_c.pc_write_cond = 1'b1;
                o_ctrl_c.pc_source     = 2'b01;
                o_ctrl_c.branch_ne     = (i_opcode == OP_BNE);
                o_next_c               = S_IF;
                o_retire_c             = 1'b1;
            end
            S_JMP: begin
                o_ctrl_c.pc_write  = 1'b1;
                o_ctrl_c.pc_source = 2'b10;
                if (i_opcode == OP_JAL) begin
                    o_ctrl_c.reg_write  = 1'b1;
                    o_ctrl_c.reg_dst    = 2'b10;
                    o_ctrl_c.mem_to_reg = 2'b10;
                end
                o_next_c   = S_IF;
                o_retire_c = 1'b1;
            end
            S_JR: begin
                o_ctrl_c.pc_write  = 1'b1;
                o_ctrl_c.pc_source = 2'b11;
                if (i_funct == F_JALR) begin
                    o_ctrl_c.reg_write  = 1'b1;
                    o_ctrl_c.reg_dst    = 2'b01;
                    o_ctrl_c.mem_to_reg = 2'b10;
                end
                o_next_c   = S_IF;
                o_retire_c = 1'b1;
            end
            S_EXC: begin
                o_ctrl_c.epc_write = 1'b1;
                o_ctrl_c.pc_write  = 1'b1;
                o_ctrl_c.exc_vec   = 1'b1;
                o_ctrl_c.illegal   = 1'b1;
                o_next_c           = S_IF;
            end
            default: o_next_c = S_IF;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU control unit: state register, retired-instruction counter,
// and reset masking of the combinational decode outputs.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W       = 4,
    parameter int unsigned MEM_HANDSHAKE = 1,
    parameter int unsigned EXC_ENABLE    = 1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         OpCode,
    input  logic [5:0]         Funct,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemWrite,
    output logic               MemRead,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               ExtOp,
    output logic               LuiOp,
    output logic [1:0]         MemtoReg,
    output logic [1:0]         RegDst,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               BranchNe,
    output logic               EPCWrite,
    output logic               ExcVec,
    output logic               illegal_o,
    output logic [3:0]         state_o,
    output logic [CNT_W-1:0]   retire_cnt
);

    state_e           r_state;
    state_e           w_next;
    ctrl_t            w_ctrl;
    ctrl_t            w_out;
    logic             w_retire;
    logic [CNT_W-1:0] r_retire_cnt;

    mc_ctrl_decode #(
        .MEM_HANDSHAKE (MEM_HANDSHAKE),
        .EXC_ENABLE    (EXC_ENABLE)
    ) u_decode (
        .i_state     (r_state),
        .i_opcode    (OpCode),
        .i_funct     (Funct),
        .i_mem_ready (mem_ready),
        .o_ctrl_c    (w_ctrl),
        .o_next_c    (w_next),
        .o_retire_c  (w_retire)
    );

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IF;
        else        r_state <= w_next;
    end

    // Reset takes priority, so an instruction cut off mid-flight is never counted.
    always_ff @(posedge clk) begin
        if (!reset)        r_retire_cnt <= '0;
        else if (w_retire) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end

    // Controls drop the moment reset asserts, not at the next edge.
    always_comb begin
        w_out = reset ? w_ctrl : '0;
        ALUOp = '0;
        ALUOp[2:0]         = w_out.alu_class;
        ALUOp[ALUOP_W-1]   = w_out.alu_unsigned;
    end

    assign PCWrite     = w_out.pc_write;
    assign PCWriteCond = w_out.pc_write_cond;
    assign IorD        = w_out.iord;
    assign MemWrite    = w_out.mem_write;
    assign MemRead     = w_out.mem_read;
    assign IRWrite     = w_out.ir_write;
    assign RegWrite    = w_out.reg_write;
    assign ExtOp       = w_out.ext_op;
    assign LuiOp       = w_out.lui_op;
    assign MemtoReg    = w_out.mem_to_reg;
    assign RegDst      = w_out.reg_dst;
    assign ALUSrcA     = w_out.alu_src_a;
    assign ALUSrcB     = w_out.alu_src_b;
    assign PCSource    = w_out.pc_source;
    assign BranchNe    = w_out.branch_ne;
    assign EPCWrite    = w_out.epc_write;
    assign ExcVec      = w_out.exc_vec;
    assign illegal_o   = w_out.illegal;
    assign state_o     = 4'(r_state);
    assign retire_cnt  = r_retire_cnt;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic       pcw, pcwc, iord, memw, memr, irw, regw, extop, luiop;
        logic [1:0] m2r, rdst, asa, asb, pcs;
        logic [2:0] cls;
        logic       bne, epc, exc, ill;
    } ctl_t;

    typedef struct {
        ctl_t        c;
        logic [3:0]  st;
        logic [31:0] cnt;
        logic        chk_u;
        logic        u;
        logic        chk_alt;
        logic [3:0]  st_alt;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, rst_alt, mem_ready;
    logic [5:0] OpCode, Funct;

    logic        PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite, RegWrite, ExtOp, LuiOp;
    logic [1:0]  MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource;
    logic [3:0]  ALUOp;
    logic        BranchNe, EPCWrite, ExcVec, illegal_o;
    logic [3:0]  state_o;
    logic [31:0] retire_cnt;

    logic        a_PCWrite, a_PCWriteCond, a_IorD, a_MemWrite, a_MemRead, a_IRWrite, a_RegWrite, a_ExtOp, a_LuiOp;
    logic [1:0]  a_MemtoReg, a_RegDst, a_ALUSrcA, a_ALUSrcB, a_PCSource;
    logic [5:0]  a_ALUOp;
    logic        a_BranchNe, a_EPCWrite, a_ExcVec, a_illegal_o;
    logic [3:0]  a_state_o;
    logic [7:0]  a_retire_cnt;

    mc_ctrl_fsm dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemWrite(MemWrite),
        .MemRead(MemRead), .IRWrite(IRWrite), .RegWrite(RegWrite), .ExtOp(ExtOp), .LuiOp(LuiOp),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALUOp(ALUOp), .BranchNe(BranchNe), .EPCWrite(EPCWrite),
        .ExcVec(ExcVec), .illegal_o(illegal_o), .state_o(state_o), .retire_cnt(retire_cnt)
    );

    mc_ctrl_fsm #(.ALUOP_W(6), .MEM_HANDSHAKE(0), .EXC_ENABLE(0), .CNT_W(8)) dut_alt (
        .clk(clk), .reset(rst_alt), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
        .PCWrite(a_PCWrite), .PCWriteCond(a_PCWriteCond), .IorD(a_IorD), .MemWrite(a_MemWrite),
        .MemRead(a_MemRead), .IRWrite(a_IRWrite), .RegWrite(a_RegWrite), .ExtOp(a_ExtOp),
        .LuiOp(a_LuiOp), .MemtoReg(a_MemtoReg), .RegDst(a_RegDst), .ALUSrcA(a_ALUSrcA),
        .ALUSrcB(a_ALUSrcB), .PCSource(a_PCSource), .ALUOp(a_ALUOp), .BranchNe(a_BranchNe),
        .EPCWrite(a_EPCWrite), .ExcVec(a_ExcVec), .illegal_o(a_illegal_o), .state_o(a_state_o),
        .retire_cnt(a_retire_cnt)
    );

    ctl_t act;
    assign act = {PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite, RegWrite, ExtOp, LuiOp,
                  MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp[2:0],
                  BranchNe, EPCWrite, ExcVec, illegal_o};

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_cnt;
    logic        g_chk_u = 1'b0, g_u = 1'b0, g_chk_alt = 1'b0;
    logic [3:0]  g_st_alt = 4'd0;

    // Hand-written per-state expectations.
    function automatic ctl_t c_zero();
        ctl_t c = '0; return c;
    endfunction
    function automatic ctl_t c_if(input logic mr);
        ctl_t c = '0; c.memr = 1'b1; c.asb = 2'b01; c.irw = mr; c.pcw = mr; return c;
    endfunction
    function automatic ctl_t c_id();
        ctl_t c = '0; c.asb = 2'b11; c.extop = 1'b1; return c;
    endfunction
    function automatic ctl_t c_exr(input logic shift);
        ctl_t c = '0; c.asa = shift ? 2'b10 : 2'b01; c.cls = 3'b010; return c;
    endfunction
    function automatic ctl_t c_exi(input logic ext, input logic lui, input logic [2:0] cls);
        ctl_t c = '0; c.asa = 2'b01; c.asb = 2'b10; c.extop = ext; c.luiop = lui; c.cls = cls; return c;
    endfunction
    function automatic ctl_t c_wbalu(input logic rtype);
        ctl_t c = '0; c.regw = 1'b1; c.m2r = 2'b01; c.rdst = rtype ? 2'b01 : 2'b00; return c;
    endfunction
    function automatic ctl_t c_addr();
        ctl_t c = '0; c.asa = 2'b01; c.asb = 2'b10; c.extop = 1'b1; return c;
    endfunction
    function automatic ctl_t c_mrd();
        ctl_t c = '0; c.memr = 1'b1; c.iord = 1'b1; return c;
    endfunction
    function automatic ctl_t c_wbmem();
        ctl_t c = '0; c.regw = 1'b1; return c;
    endfunction
    function automatic ctl_t c_mwr();
        ctl_t c = '0; c.memw = 1'b1; c.iord = 1'b1; return c;
    endfunction
    function automatic ctl_t c_br(input logic ne);
        ctl_t c = '0; c.asa = 2'b01; c.cls = 3'b001; c.pcwc = 1'b1; c.pcs = 2'b01; c.bne = ne; return c;
    endfunction
    function automatic ctl_t c_jmp(input logic link);
        ctl_t c = '0; c.pcw = 1'b1; c.pcs = 2'b10;
        if (link) begin c.regw = 1'b1; c.rdst = 2'b10; c.m2r = 2'b10; end
        return c;
    endfunction
    function automatic ctl_t c_jr(input logic link);
        ctl_t c = '0; c.pcw = 1'b1; c.pcs = 2'b11;
        if (link) begin c.regw = 1'b1; c.rdst = 2'b01; c.m2r = 2'b10; end
        return c;
    endfunction
    function automatic ctl_t c_exc();
        ctl_t c = '0; c.epc = 1'b1; c.pcw = 1'b1; c.exc = 1'b1; c.ill = 1'b1; return c;
    endfunction

    task automatic cyc(input ctl_t c, input logic [3:0] st, input string nm);
        exp_t e;
        e.c = c; e.st = st; e.cnt = exp_cnt; e.chk_u = g_chk_u; e.u = g_u;
        e.chk_alt = g_chk_alt; e.st_alt = g_st_alt; e.nm = nm;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input string nm);
        OpCode = op; Funct = fn; mem_ready = 1'b1;
        cyc(c_if(1'b1), 4'd0, {nm, "_if"});
        cyc(c_id(), 4'd1, {nm, "_id"});
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (act !== e.c) begin
                bad++;
                $display("FAIL %s ctl: got %h want %h", e.nm, act, e.c);
            end
            total++;
            if (state_o !== e.st) begin
                bad++;
                $display("FAIL %s state: got %0d want %0d", e.nm, state_o, e.st);
            end
            total++;
            if (retire_cnt !== e.cnt) begin
                bad++;
                $display("FAIL %s retire_cnt: got %0d want %0d", e.nm, retire_cnt, e.cnt);
            end
            if (e.chk_u) begin
                total++;
                if (ALUOp[3] !== e.u) begin
                    bad++;
                    $display("FAIL %s aluop_unsigned: got %b want %b", e.nm, ALUOp[3], e.u);
                end
            end
            if (e.chk_alt) begin
                total++;
                if (a_state_o !== e.st_alt || a_illegal_o !== 1'b0 || a_ExcVec !== 1'b0) begin
                    bad++;
                    $display("FAIL %s alt_dut: got state=%0d ill=%b exc=%b want state=%0d ill=0 exc=0",
                             e.nm, a_state_o, a_illegal_o, a_ExcVec, e.st_alt);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; rst_alt = 1'b0; mem_ready = 1'b0;
        OpCode = 6'h00; Funct = 6'h00; exp_cnt = 32'd0;
        @(posedge clk); #1;
        cyc(c_zero(), 4'd0, "rst0");
        cyc(c_zero(), 4'd0, "rst1");
        reset = 1'b1;

        fetch(6'h00, 6'h20, "add");
        cyc(c_exr(1'b0), 4'd2, "add_exr");
        cyc(c_wbalu(1'b1), 4'd4, "add_wb"); exp_cnt++;

        fetch(6'h23, 6'h00, "lw");
        cyc(c_addr(), 4'd5, "lw_addr");
        mem_ready = 1'b0;
        repeat (3) cyc(c_mrd(), 4'd6, "lw_mrd_wait");
        mem_ready = 1'b1;
        cyc(c_mrd(), 4'd6, "lw_mrd_done");
        cyc(c_wbmem(), 4'd7, "lw_wb"); exp_cnt++;

        fetch(6'h05, 6'h00, "bne");
        cyc(c_br(1'b1), 4'd9, "bne_br"); exp_cnt++;
        fetch(6'h04, 6'h00, "beq");
        cyc(c_br(1'b0), 4'd9, "beq_br"); exp_cnt++;

        OpCode = 6'h03; mem_ready = 1'b0;
        cyc(c_if(1'b0), 4'd0, "jal_if_wait");
        fetch(6'h03, 6'h00, "jal");
        cyc(c_jmp(1'b1), 4'd10, "jal_jmp"); exp_cnt++;
        fetch(6'h02, 6'h00, "j");
        cyc(c_jmp(1'b0), 4'd10, "j_jmp"); exp_cnt++;
        fetch(6'h00, 6'h09, "jalr");
        cyc(c_jr(1'b1), 4'd11, "jalr_jr"); exp_cnt++;
        fetch(6'h00, 6'h08, "jr");
        cyc(c_jr(1'b0), 4'd11, "jr_jr"); exp_cnt++;

        fetch(6'h0b, 6'h00, "sltiu");
        g_chk_u = 1'b1; g_u = 1'b1;
        cyc(c_exi(1'b1, 1'b0, 3'b100), 4'd3, "sltiu_exi");
        g_chk_u = 1'b0;
        cyc(c_wbalu(1'b0), 4'd4, "sltiu_wb"); exp_cnt++;
        fetch(6'h0c, 6'h00, "andi");
        g_chk_u = 1'b1; g_u = 1'b0;
        cyc(c_exi(1'b0, 1'b0, 3'b011), 4'd3, "andi_exi");
        g_chk_u = 1'b0;
        cyc(c_wbalu(1'b0), 4'd4, "andi_wb"); exp_cnt++;
        fetch(6'h0f, 6'h00, "lui");
        cyc(c_exi(1'b1, 1'b1, 3'b000), 4'd3, "lui_exi");
        cyc(c_wbalu(1'b0), 4'd4, "lui_wb"); exp_cnt++;
        fetch(6'h00, 6'h00, "sll");
        cyc(c_exr(1'b1), 4'd2, "sll_exr");
        cyc(c_wbalu(1'b1), 4'd4, "sll_wb"); exp_cnt++;

        OpCode = 6'h3f; Funct = 6'h00; mem_ready = 1'b1; rst_alt = 1'b1;
        g_chk_alt = 1'b1; g_st_alt = 4'd0;
        cyc(c_if(1'b1), 4'd0, "ill_if");
        g_st_alt = 4'd1;
        cyc(c_id(), 4'd1, "ill_id");
        g_st_alt = 4'd0;
        cyc(c_exc(), 4'd12, "ill_exc");
        g_chk_alt = 1'b0; rst_alt = 1'b0;
        fetch(6'h00, 6'h01, "badfn");
        cyc(c_exc(), 4'd12, "badfn_exc");

        fetch(6'h2b, 6'h00, "sw");
        cyc(c_addr(), 4'd5, "sw_addr");
        mem_ready = 1'b0;
        cyc(c_mwr(), 4'd8, "sw_wait");
        reset = 1'b0;
        cyc(c_zero(), 4'd8, "sw_rst_now");
        exp_cnt = 32'd0;
        cyc(c_zero(), 4'd0, "post_rst");
        reset = 1'b1;
        fetch(6'h2b, 6'h00, "sw2");
        cyc(c_addr(), 4'd5, "sw2_addr");
        mem_ready = 1'b1;
        cyc(c_mwr(), 4'd8, "sw2_mwr"); exp_cnt++;
        cyc(c_if(1'b1), 4'd0, "final_if");

        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
